// File: rtl/dcache_pkg.sv
// Shared definitions for the data cache and its miss-handling controller.
package dcache_pkg;

   localparam int BLOCK_W         = 29;
   localparam int OFFSET_W        = 3;
   localparam int DEF_MEM_TIMEOUT = 64;
   localparam int TIMER_W         = 8;

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_REQ  = 2'd1;
   localparam logic [1:0] ST_FILL = 2'd2;
   localparam logic [1:0] ST_ERR  = 2'd3;

   typedef struct packed {
      logic [BLOCK_W-1:0] block;
      logic               write;
      logic [31:0]        wdata;
   } miss_cap_t;

   function automatic logic [31:0] block_to_addr(input logic [BLOCK_W-1:0] block);
      return {block, {OFFSET_W{1'b0}}};
   endfunction

endpackage

// File: rtl/dcache_refill_ctrl_refill_timer.sv
// Watchdog for the memory request phase: counts enabled cycles, holds at the limit.
module refill_timer
   import dcache_pkg::*;
(
   input  logic               clk,
   input  logic               reset,
   input  logic               clear,
   input  logic               enable,
   input  logic [TIMER_W-1:0] limit,
   output logic               expired
);

   logic [TIMER_W-1:0] count_r;

   assign expired = (count_r == limit);

   // Cycle counter, frozen once the limit is reached
   always_ff @(posedge clk) begin
      if (reset) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (clear) begin
         count_r <= {TIMER_W{1'b0}};
      end else if (enable && !expired) begin
         count_r <= count_r + {{(TIMER_W-1){1'b0}}, 1'b1};
      end else begin
         count_r <= count_r;
      end
   end

endmodule

// File: rtl/dcache_refill_ctrl.sv
// Single-outstanding data cache miss controller: stall, one-word memory
// transaction, one-cycle fill back to the cache, miss counter and timeout flag.
module dcache_refill_ctrl
   import dcache_pkg::*;
#(
   parameter int MEM_TIMEOUT = DEF_MEM_TIMEOUT,
   parameter int CNT_W       = 16
) (
   input  logic               clk,
   input  logic               reset,
   input  logic               miss_valid,
   input  logic [31:0]        miss_addr,
   input  logic               miss_write,
   input  logic [31:0]        miss_wdata,
   output logic               stall,
   output logic               fill_valid,
   output logic [BLOCK_W-1:0] fill_block,
   output logic [31:0]        fill_data,
   output logic               mem_req,
   output logic               mem_we,
   output logic [31:0]        mem_addr,
   output logic [31:0]        mem_wdata,
   input  logic [31:0]        mem_rdata,
   input  logic               mem_ack,
   output logic [CNT_W-1:0]   miss_count,
   output logic               timeout_err
);

   // The timer starts at zero in the first REQ cycle, so the limit is one less
   // than the number of REQ cycles allowed.
   localparam logic [TIMER_W-1:0] TIMER_LIMIT = TIMER_W'(MEM_TIMEOUT - 1);

   logic [1:0]         state_r;
   logic [1:0]         state_n_s;
   logic               accept_s;
   logic               ack_s;
   logic               timeout_s;
   logic               expired_s;
   miss_cap_t          cap_r;
   logic               mem_req_r;
   logic               fill_valid_r;
   logic [BLOCK_W-1:0] fill_block_r;
   logic [31:0]        fill_data_r;
   logic [CNT_W-1:0]   miss_count_r;
   logic               timeout_err_r;
   logic               unused_s;

   assign unused_s = &{1'b0, miss_addr[OFFSET_W-1:0]};

   refill_timer u_timer (
      .clk     (clk),
      .reset   (reset),
      .clear   (state_r != ST_REQ),
      .enable  (state_r == ST_REQ),
      .limit   (TIMER_LIMIT),
      .expired (expired_s)
   );

   // Next-state decode; ack in the expiry cycle takes priority over timeout
   always_comb begin
      state_n_s = state_r;
      accept_s  = 1'b0;
      ack_s     = 1'b0;
      timeout_s = 1'b0;
      case (state_r)
         ST_IDLE: begin
            if (miss_valid) begin
               state_n_s = ST_REQ;
               accept_s  = 1'b1;
            end else begin
               state_n_s = ST_IDLE;
            end
         end
         ST_REQ: begin
            if (mem_ack) begin
               state_n_s = ST_FILL;
               ack_s     = 1'b1;
            end else if (expired_s) begin
               state_n_s = ST_ERR;
               timeout_s = 1'b1;
            end else begin
               state_n_s = ST_REQ;
            end
         end
         ST_FILL: state_n_s = ST_IDLE;
         ST_ERR:  state_n_s = ST_ERR;
         default: state_n_s = ST_IDLE;
      endcase
   end

   // State, captured miss and all registered outputs
   always_ff @(posedge clk) begin
      if (reset) begin
         state_r       <= ST_IDLE;
         cap_r         <= '0;
         mem_req_r     <= 1'b0;
         fill_valid_r  <= 1'b0;
         fill_block_r  <= {BLOCK_W{1'b0}};
         fill_data_r   <= 32'h0000_0000;
         miss_count_r  <= {CNT_W{1'b0}};
         timeout_err_r <= 1'b0;
      end else begin
         state_r      <= state_n_s;
         mem_req_r    <= (state_n_s == ST_REQ);
         fill_valid_r <= ack_s;
         if (accept_s) begin
            cap_r.block <= miss_addr[31:OFFSET_W];
            cap_r.write <= miss_write;
            cap_r.wdata <= miss_wdata;
            if (miss_count_r != {CNT_W{1'b1}}) begin
               miss_count_r <= miss_count_r + {{(CNT_W-1){1'b0}}, 1'b1};
            end else begin
               miss_count_r <= miss_count_r;
            end
         end else begin
            cap_r        <= cap_r;
            miss_count_r <= miss_count_r;
         end
         // Write-allocate: a write miss installs its own data
         if (ack_s) begin
            fill_block_r <= cap_r.block;
            fill_data_r  <= cap_r.write ? cap_r.wdata : mem_rdata;
         end else begin
            fill_block_r <= fill_block_r;
            fill_data_r  <= fill_data_r;
         end
         timeout_err_r <= timeout_err_r | timeout_s;
      end
   end

   assign stall       = (state_r != ST_IDLE) | miss_valid;
   assign mem_req     = mem_req_r;
   assign mem_we      = cap_r.write;
   assign mem_addr    = block_to_addr(cap_r.block);
   assign mem_wdata   = cap_r.wdata;
   assign fill_valid  = fill_valid_r;
   assign fill_block  = fill_block_r;
   assign fill_data   = fill_data_r;
   assign miss_count  = miss_count_r;
   assign timeout_err = timeout_err_r;

endmodule

// File: tb/tb_dcache_refill_ctrl.sv
// Directed bench for dcache_refill_ctrl: vector table plus multi-cycle sequences.
module tb_dcache_refill_ctrl;

   typedef struct packed {
      logic        stall;
      logic        mem_req;
      logic        mem_we;
      logic [31:0] mem_addr;
      logic [31:0] mem_wdata;
      logic        fill_valid;
      logic [28:0] fill_block;
      logic [31:0] fill_data;
      logic [1:0]  miss_count;
      logic        timeout_err;
   } outs_t;

   typedef struct {
      logic        mv;
      logic [31:0] ma;
      logic        mw;
      logic [31:0] md;
      logic        ack;
      logic [31:0] rd;
      outs_t       exp;
   } vec_t;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic        miss_valid = 1'b0;
   logic [31:0] miss_addr = 32'h0;
   logic        miss_write = 1'b0;
   logic [31:0] miss_wdata = 32'h0;
   logic        stall, fill_valid, mem_req, mem_we, timeout_err;
   logic [28:0] fill_block;
   logic [31:0] fill_data, mem_addr, mem_wdata;
   logic [31:0] mem_rdata = 32'h0;
   logic        mem_ack = 1'b0;
   logic [1:0]  miss_count;

   int total = 0;
   int bad = 0;
   vec_t vecs[17];

   always #5 clk = ~clk;

   dcache_refill_ctrl #(.MEM_TIMEOUT(4), .CNT_W(2)) dut (
      .clk(clk), .reset(reset),
      .miss_valid(miss_valid), .miss_addr(miss_addr), .miss_write(miss_write),
      .miss_wdata(miss_wdata), .stall(stall), .fill_valid(fill_valid),
      .fill_block(fill_block), .fill_data(fill_data), .mem_req(mem_req),
      .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .mem_ack(mem_ack), .miss_count(miss_count),
      .timeout_err(timeout_err)
   );

   function automatic outs_t o(logic s, logic rq, logic we, logic [31:0] a, logic [31:0] wd,
                               logic fv, logic [28:0] fb, logic [31:0] fd, logic [1:0] c, logic e);
      return '{s, rq, we, a, wd, fv, fb, fd, c, e};
   endfunction

   function automatic outs_t actual();
      return '{stall, mem_req, mem_we, mem_addr, mem_wdata, fill_valid,
               fill_block, fill_data, miss_count, timeout_err};
   endfunction

   task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
      total++;
      if (act !== exp) begin
         bad++;
         $display("FAIL %s: got %h want %h", name, act, exp);
      end
   endtask

   task automatic next_cycle();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(logic mv, logic [31:0] ma, logic mw, logic [31:0] md, logic ack, logic [31:0] rd);
      miss_valid = mv; miss_addr = ma; miss_write = mw; miss_wdata = md;
      mem_ack = ack; mem_rdata = rd;
   endtask

   task automatic do_reset();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
   endtask

   initial begin
      int n;
      outs_t act;
      // read miss at 0x1014, ack in third REQ cycle
      vecs[0]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b0,1'b0,1'b0,32'h0,32'h0,1'b0,29'h0,32'h0,2'd0,1'b0)};
      vecs[1]  = '{1'b1, 32'h1014,   1'b0, 32'h0, 1'b0, 32'h0, o(1'b1,1'b0,1'b0,32'h0,32'h0,1'b0,29'h0,32'h0,2'd0,1'b0)};
      vecs[2]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b1,1'b1,1'b0,32'h1010,32'h0,1'b0,29'h0,32'h0,2'd1,1'b0)};
      vecs[3]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b1,1'b1,1'b0,32'h1010,32'h0,1'b0,29'h0,32'h0,2'd1,1'b0)};
      vecs[4]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 32'hDEAD_BEEF, o(1'b1,1'b1,1'b0,32'h1010,32'h0,1'b0,29'h0,32'h0,2'd1,1'b0)};
      vecs[5]  = '{1'b1, 32'h999,    1'b1, 32'h5555, 1'b1, 32'h0, o(1'b1,1'b0,1'b0,32'h1010,32'h0,1'b1,29'h202,32'hDEAD_BEEF,2'd1,1'b0)};
      vecs[6]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b0,1'b0,1'b0,32'h1010,32'h0,1'b0,29'h202,32'hDEAD_BEEF,2'd1,1'b0)};
      // write miss at 0x40, ack in first REQ cycle; rdata must not be used
      vecs[7]  = '{1'b1, 32'h40,     1'b1, 32'h1234_5678, 1'b0, 32'h0, o(1'b1,1'b0,1'b0,32'h1010,32'h0,1'b0,29'h202,32'hDEAD_BEEF,2'd1,1'b0)};
      vecs[8]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF, o(1'b1,1'b1,1'b1,32'h40,32'h1234_5678,1'b0,29'h202,32'hDEAD_BEEF,2'd2,1'b0)};
      vecs[9]  = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b1,1'b0,1'b1,32'h40,32'h1234_5678,1'b1,29'h8,32'h1234_5678,2'd2,1'b0)};
      // back-to-back read miss at 0x80; ack in the expiry cycle wins
      vecs[10] = '{1'b1, 32'h80,     1'b0, 32'hAAAA_0000, 1'b0, 32'h0, o(1'b1,1'b0,1'b1,32'h40,32'h1234_5678,1'b0,29'h8,32'h1234_5678,2'd2,1'b0)};
      vecs[11] = '{1'b1, 32'h200,    1'b1, 32'h0, 1'b0, 32'h0, o(1'b1,1'b1,1'b0,32'h80,32'hAAAA_0000,1'b0,29'h8,32'h1234_5678,2'd3,1'b0)};
      vecs[12] = '{1'b1, 32'h200,    1'b1, 32'h0, 1'b0, 32'h0, o(1'b1,1'b1,1'b0,32'h80,32'hAAAA_0000,1'b0,29'h8,32'h1234_5678,2'd3,1'b0)};
      vecs[13] = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b1,1'b1,1'b0,32'h80,32'hAAAA_0000,1'b0,29'h8,32'h1234_5678,2'd3,1'b0)};
      vecs[14] = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b1, 32'h0BAD_F00D, o(1'b1,1'b1,1'b0,32'h80,32'hAAAA_0000,1'b0,29'h8,32'h1234_5678,2'd3,1'b0)};
      vecs[15] = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b1,1'b0,1'b0,32'h80,32'hAAAA_0000,1'b1,29'h10,32'h0BAD_F00D,2'd3,1'b0)};
      vecs[16] = '{1'b0, 32'h0,      1'b0, 32'h0, 1'b0, 32'h0, o(1'b0,1'b0,1'b0,32'h80,32'hAAAA_0000,1'b0,29'h10,32'h0BAD_F00D,2'd3,1'b0)};

      next_cycle();
      next_cycle();
      reset = 1'b0;
      for (int i = 0; i < 17; i++) begin
         drive(vecs[i].mv, vecs[i].ma, vecs[i].mw, vecs[i].md, vecs[i].ack, vecs[i].rd);
         @(negedge clk);
         act = actual();
         total++;
         if (act !== vecs[i].exp) begin
            bad++;
            $display("FAIL vec%0d: got %h want %h", i, act, vecs[i].exp);
         end
         next_cycle();
      end

      // timeout: mem_req for exactly 4 cycles, then stuck in error
      do_reset();
      drive(1'b1, 32'h300, 1'b0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      n = 0;
      for (int i = 0; i < 20; i++) begin
         @(negedge clk);
         if (mem_req) n++;
         if (i == 10) miss_valid = 1'b1;
         next_cycle();
      end
      @(negedge clk);
      chk("timeout_req_cycles", 64'(n), 64'd4);
      chk("timeout_err_set", 64'(timeout_err), 64'd1);
      chk("timeout_stall", 64'(stall), 64'd1);
      chk("timeout_req_low", 64'(mem_req), 64'd0);
      do_reset();
      @(negedge clk);
      chk("timeout_err_cleared", 64'(timeout_err), 64'd0);
      chk("timeout_stall_cleared", 64'(stall), 64'd0);

      // reset mid-REQ, then a late ack
      do_reset();
      drive(1'b1, 32'h1238, 1'b1, 32'h7777_7777, 1'b0, 32'h0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      next_cycle();
      reset = 1'b1;
      next_cycle();
      reset = 1'b0;
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'hFFFF_FFFF);
      @(negedge clk);
      chk("rst_mid_req_outs", 64'(actual()), 64'd0);
      next_cycle();
      drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
      @(negedge clk);
      chk("late_ack_no_fill", 64'({fill_valid, mem_req, stall}), 64'd0);
      chk("late_ack_count", 64'(miss_count), 64'd0);

      // counter saturation at 3 over six misses
      do_reset();
      for (int k = 0; k < 6; k++) begin
         drive(1'b1, 32'(k * 8), 1'b0, 32'h0, 1'b0, 32'h0);
         next_cycle();
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b1, 32'(k));
         next_cycle();
         drive(1'b0, 32'h0, 1'b0, 32'h0, 1'b0, 32'h0);
         next_cycle();
         @(negedge clk);
         chk($sformatf("sat_count_%0d", k), 64'(miss_count), (k >= 2) ? 64'd3 : 64'(k + 1));
         next_cycle();
      end

      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
